// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath widths and writeback result-select encodings.
package riscv_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_MEM  = 2'b01,
      RES_PC4  = 2'b10,
      RES_RSVD = 2'b11
   } result_src_e;

endpackage : riscv_pkg

// File: rtl/wb_result_mux.sv
// Writeback result select (ALU / load data / PC+4, reserved code yields 0).
// Shared with the EX-stage forwarding path.
module wb_result_mux
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [1:0]      sel_i,
   input  logic [XLEN-1:0] alu_i,
   input  logic [XLEN-1:0] mem_i,
   input  logic [XLEN-1:0] pc4_i,
   output logic [XLEN-1:0] result_o
);

   always_comb begin
      result_o = '0;
      unique case (result_src_e'(sel_i))
         RES_ALU:  result_o = alu_i;
         RES_MEM:  result_o = mem_i;
         RES_PC4:  result_o = pc4_i;
         default:  result_o = '0;
      endcase
   end

endmodule : wb_result_mux

// File: rtl/wb_regfile.sv
// RV32I writeback stage and 32-entry integer register file with two async read ports.
// Define WB_REGFILE_BYPASS_EN to forward the in-flight ResultW to same-cycle reads.
module wb_regfile
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RegWriteW,
   input  logic [1:0]           ResultSrcW,
   input  logic [XLEN-1:0]      ALUResultW,
   input  logic [XLEN-1:0]      ReadDataW,
   input  logic [XLEN-1:0]      PCPlus4W,
   input  logic [REG_IDX_W-1:0] RdW,
   input  logic [REG_IDX_W-1:0] Rs1D,
   input  logic [REG_IDX_W-1:0] Rs2D,
   output logic [XLEN-1:0]      RD1D,
   output logic [XLEN-1:0]      RD2D,
   output logic [XLEN-1:0]      ResultW
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic            commit;

   wb_result_mux #(.XLEN(XLEN)) u_result_mux (
      .sel_i    (ResultSrcW),
      .alu_i    (ALUResultW),
      .mem_i    (ReadDataW),
      .pc4_i    (PCPlus4W),
      .result_o (ResultW)
   );

   assign commit = RegWriteW && (RdW != '0) && !rst;

   always_comb begin
      regs_d = regs_q;
      if (commit) regs_d[RdW] = ResultW;
   end

   // Reset wins over a concurrent commit, so the write is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      RD1D = (Rs1D == '0) ? '0 : regs_q[Rs1D];
      RD2D = (Rs2D == '0) ? '0 : regs_q[Rs2D];
`ifdef WB_REGFILE_BYPASS_EN
      // commit already excludes x0 and reset, so x0 reads stay zero.
      if (commit && (RdW == Rs1D)) RD1D = ResultW;
      if (commit && (RdW == Rs2D)) RD2D = ResultW;
`endif
   end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow WB_REGFILE_BYPASS_EN.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW, Rs1D, Rs2D;
   logic [31:0] RD1D, RD2D, ResultW;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] model [32];

`ifdef WB_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   wb_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RD1D       (RD1D),
      .RD2D       (RD2D),
      .ResultW    (ResultW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_alu(input logic [4:0] rd, input logic [31:0] val);
      RegWriteW  = 1'b1;
      ResultSrcW = 2'b00;
      RdW        = rd;
      ALUResultW = val;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 32; i++) begin
         Rs1D = 5'(i);
         Rs2D = 5'(31 - i);
         #1;
         chk($sformatf("%s_rd1_x%0d", tag, i), RD1D, model[i]);
         chk($sformatf("%s_rd2_x%0d", tag, 31 - i), RD2D, model[31 - i]);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      rst = 1'b1; RegWriteW = 1'b0; ResultSrcW = 2'b00;
      ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0;
      RdW = '0; Rs1D = '0; Rs2D = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset_resultw", ResultW, 32'h0);
      check_all("reset");

      // Preload x5, then reset with a concurrent write to x7
      wr_alu(5'd5, 32'hDEADBEEF);
      tick();
      RegWriteW = 1'b0; Rs1D = 5'd5; Rs2D = 5'd5;
      #1;
      chk("preload_x5", RD1D, 32'hDEADBEEF);
      wr_alu(5'd7, 32'h0000_1234);
      rst = 1'b1;
      tick();
      rst = 1'b0; RegWriteW = 1'b0; ALUResultW = '0;
      check_all("midrst");

      // Result select sweep with writeback disabled
      ALUResultW = 32'h11; ReadDataW = 32'h22; PCPlus4W = 32'h33;
      ResultSrcW = 2'b00; #1; chk("sel_alu", ResultW, 32'h11);
      ResultSrcW = 2'b01; #1; chk("sel_mem", ResultW, 32'h22);
      ResultSrcW = 2'b10; #1; chk("sel_pc4", ResultW, 32'h33);
      ResultSrcW = 2'b11; #1; chk("sel_rsvd", ResultW, 32'h0);

      // x0 protection
      wr_alu(5'd0, 32'hFFFFFFFF);
      Rs1D = 5'd0; Rs2D = 5'd0;
      #1;
      chk("x0_pre_rd1", RD1D, 32'h0);
      chk("x0_pre_rd2", RD2D, 32'h0);
      tick();
      RegWriteW = 1'b0;
      #1;
      chk("x0_post_rd1", RD1D, 32'h0);
      chk("x0_post_rd2", RD2D, 32'h0);

      // Same-cycle hazard on x3
      wr_alu(5'd3, 32'h5);
      tick();
      model[3] = 32'h5;
      wr_alu(5'd3, 32'hA);
      Rs1D = 5'd3; Rs2D = 5'd3;
      #1;
      chk("haz_pre_rd1", RD1D, BYP ? 32'hA : 32'h5);
      chk("haz_pre_rd2", RD2D, BYP ? 32'hA : 32'h5);
      tick();
      model[3] = 32'hA;
      RegWriteW = 1'b0;
      #1;
      chk("haz_post_rd1", RD1D, 32'hA);
      chk("haz_post_rd2", RD2D, 32'hA);

      // Write disabled: x9 untouched, no bypass
      RegWriteW = 1'b0; RdW = 5'd9; ALUResultW = 32'h77; ResultSrcW = 2'b00;
      Rs1D = 5'd9; Rs2D = 5'd9;
      #1;
      chk("nowr_resultw", ResultW, 32'h77);
      chk("nowr_pre_rd1", RD1D, 32'h0);
      chk("nowr_pre_rd2", RD2D, 32'h0);
      tick();
      chk("nowr_post_rd1", RD1D, 32'h0);

      // Back-to-back writes, including the top register and each mux source
      wr_alu(5'd4, 32'h1);
      tick();
      ResultSrcW = 2'b01; ReadDataW = 32'h2; ALUResultW = 32'hBAD0_0000;
      tick();
      ResultSrcW = 2'b10; PCPlus4W = 32'h8000_0000; RdW = 5'd31;
      tick();
      RegWriteW = 1'b0;
      model[4]  = 32'h2;
      model[31] = 32'h8000_0000;
      check_all("b2b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no completion, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural integer register file for the RV32I 5-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback result, and commits it to the 32-entry register file on the rising clock edge. Provides two asynchronous read ports to the decode stage, with an optional same-cycle write-to-read bypass. Also drives `ResultW` to the EX-stage forwarding mux.

## Interface
Parameters:
- `XLEN`, 32, data width of registers and results
- `NREGS`, 32, number of architectural registers; index width is log2(`NREGS`) = 5

Ports:
- Clock and reset are `clk` and `rst`: one clock; reset is synchronous and active-high.
- `clk` in 1: single clock; all state updates on the posedge.
- `rst` in 1: synchronous, active-high reset.
- `RegWriteW` in 1: writeback enable.
- `ResultSrcW` in 2: result select.
- `ALUResultW` in XLEN: ALU result.
- `ReadDataW` in XLEN: load data.
- `PCPlus4W` in XLEN: link value for JAL/JALR.
- `RdW` in 5: destination register index.
- `Rs1D` in 5: decode read address, port 1.
- `Rs2D` in 5: decode read address, port 2.
- `RD1D` out XLEN: read data, port 1.
- `RD2D` out XLEN: read data, port 2.
- `ResultW` out XLEN: selected writeback value, sent to forwarding.

## Operation
- Result select by `ResultSrcW`:
  - 00 → `ALUResultW`
  - 01 → `ReadDataW`
  - 10 → `PCPlus4W`
  - 11 (reserved) → 0
- `ResultW` is purely combinational from the W-stage inputs. It is valid even when `RegWriteW`=0.
- Commit condition: `RegWriteW`=1 and `RdW`≠0 and `rst`=0. On that posedge, `regs[RdW]` ← `ResultW`.
- x0 is hardwired to zero:
  - Writes to index 0 are discarded.
  - A read of index 0 always returns 0, regardless of array contents or bypass.
- Reads are asynchronous: `RD1D` = `regs[Rs1D]`, `RD2D` = `regs[Rs2D]`. The two ports are independent; `Rs1D`=`Rs2D` is legal.
- Reset:
  - On a posedge with `rst`=1, all entries clear to 0. Reset takes priority over a concurrent write, so the write is lost.
  - Outputs after reset: `RD1D`=`RD2D`=0 for every address. `ResultW` still follows its inputs; the MEM/WB register drives them to 0 during reset, so `ResultW`=0.
- No arithmetic widening: all data paths are exactly XLEN bits with no sign or zero extension. Load extension is done upstream in MEM.

## Timing
- Write latency: one edge. A value committed at posedge N is visible on the read ports from just after edge N (async read).
- Same-cycle write and read of the same register, before the commit edge:
  - With bypass enabled: the read returns the new `ResultW`.
  - Without bypass: the read returns the old array value.
- Back-to-back writes to the same `RdW` on consecutive cycles: each commits in order; the last one wins.
- A mid-operation `rst` pulse of one cycle clears the whole array. No partial state survives.
- Combinational paths: W inputs → `ResultW` → `RD1D`/`RD2D` (bypass only). `Rs1D`/`Rs2D` → `RD1D`/`RD2D`. There are no other combinational loops.

## Configuration
- Macro: `WB_REGFILE_BYPASS_EN`.
- Defined:
  - `RD1D` = `ResultW` when `RegWriteW`=1, `RdW`=`Rs1D`, `RdW`≠0, and `rst`=0.
  - `RD2D` is bypassed under the same rule using `Rs2D`.
  - This removes the decode-after-writeback hazard.
- Undefined:
  - No bypass logic; reads see array contents only.
  - The hazard unit must stall decode one extra cycle whenever Rs1D/Rs2D matches `RdW` with `RegWriteW`=1.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN_DEF` = 32 and `REG_IDX_W` = 5.
  - ResultSrc encodings: `RES_ALU` = 2'b00, `RES_MEM` = 2'b01, `RES_PC4` = 2'b10.
- Sub-module `wb_result_mux`: the combinational 4:1 result select. It is reused by the forwarding path.
- Top-level contents: the register array, write port, read ports, and the optional bypass.

## Test plan
- Reset: preload x5=0xDEADBEEF, then assert `rst` for 1 cycle → reads of x0–x31 all return 0. A write to x7 issued in the same cycle as reset is lost.
- Result select: `ALUResultW`=0x11, `ReadDataW`=0x22, `PCPlus4W`=0x33, sweep `ResultSrcW` 00/01/10/11 → `ResultW` = 0x11/0x22/0x33/0x0.
- x0 protection: `RegWriteW`=1, `RdW`=0, `ALUResultW`=0xFFFFFFFF → after the edge, read x0 = 0 on both ports. With bypass built, the bypass does not fire.
- Same-cycle hazard: x3=0x5 already stored; write x3←0xA while `Rs1D`=`Rs2D`=3 → `RD1D`/`RD2D` = 0xA before the edge with `WB_REGFILE_BYPASS_EN`, 0x5 without it. Both read 0xA after the edge.
- `RegWriteW`=0 with `RdW`=9 and `ResultW`=0x77 → x9 is unchanged, and the bypass does not fire.
- Back-to-back: write x4←1, then x4←2 on the next cycle, then x31←0x80000000 → read x4=2 and x31=0x80000000; all other registers unchanged.
